// File: rtl/frame_capture_ctrl_if.sv
// Video/control bundle for frame_capture_ctrl: slave = sequencer side,
// master = source/host side driving beats and commands.
interface frame_capture_ctrl_if;
   logic        i_start;
   logic        i_abort;
   logic [7:0]  i_skip_frames;
   logic [7:0]  i_capture_frames;
   logic        i_hsync;
   logic        i_vsync;
   logic        i_pixel_valid;
   logic [63:0] i_pixel_data;
   logic        o_pixel_valid;
   logic [63:0] o_pixel_data;
   logic        o_frame_start;
   logic        o_frame_end;
   logic [7:0]  o_frame_idx;
   logic        o_busy;
   logic        o_done;
   logic        o_err_geom;

   modport master (
      output i_start, i_abort, i_skip_frames, i_capture_frames,
             i_hsync, i_vsync, i_pixel_valid, i_pixel_data,
      input  o_pixel_valid, o_pixel_data, o_frame_start, o_frame_end,
             o_frame_idx, o_busy, o_done, o_err_geom
   );

   modport slave (
      input  i_start, i_abort, i_skip_frames, i_capture_frames,
             i_hsync, i_vsync, i_pixel_valid, i_pixel_data,
      output o_pixel_valid, o_pixel_data, o_frame_start, o_frame_end,
             o_frame_idx, o_busy, o_done, o_err_geom
   );
endinterface

// File: rtl/frame_capture_ctrl.sv
// Frame capture sequencer: align to vsync, skip leading frames, forward N frames.
// Optional line/frame geometry checking is built when FRAME_CAP_GEOM_CHECK_EN is defined.
module frame_capture_ctrl #(
   parameter int unsigned IMG_WIDTH       = 1920,
   parameter int unsigned IMG_HEIGHT      = 1080,
   parameter int unsigned PIXEL_PER_CLOCK = 4,
   parameter int unsigned CNT_W           = 16
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   frame_capture_ctrl_if.slave  bus
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ARM,
      ST_SKIP,
      ST_CAPTURE,
      ST_DONE
   } state_e;

   state_e      state_q, state_d;
   logic [7:0]  skip_q, skip_d;
   logic [7:0]  cap_q, cap_d;
   logic [7:0]  skip_cnt_q, skip_cnt_d;
   logic [7:0]  idx_q, idx_d;
   logic        done_q, done_d;
   logic        busy_q, busy_d;
   logic        fs_q, fs_d;
   logic        fe_q, fe_d;
   logic        pv_q, pv_d;
   logic [63:0] pd_q, pd_d;
   logic        vsync_d1_q;
   logic        err_q;

   logic        vrise, vfall;
   logic        fwd;
   logic        arm_go;
   logic        err_clr;

   assign vrise = bus.i_vsync & ~vsync_d1_q;
   assign vfall = ~bus.i_vsync & vsync_d1_q;

   always_comb begin
      state_d    = state_q;
      skip_d     = skip_q;
      cap_d      = cap_q;
      skip_cnt_d = skip_cnt_q;
      idx_d      = idx_q;
      done_d     = done_q;
      fs_d       = 1'b0;
      fe_d       = 1'b0;
      fwd        = 1'b0;
      arm_go     = 1'b0;
      err_clr    = 1'b0;

      // Abort wins over every other command, including a same-cycle start.
      if (bus.i_abort) begin
         state_d = ST_IDLE;
      end else begin
         unique case (state_q)
            ST_IDLE, ST_DONE: begin
               if (bus.i_start) begin
                  skip_d     = bus.i_skip_frames;
                  cap_d      = bus.i_capture_frames;
                  skip_cnt_d = '0;
                  idx_d      = '0;
                  err_clr    = 1'b1;
                  if (bus.i_capture_frames == 8'd0) begin
                     state_d = ST_DONE;
                     done_d  = 1'b1;
                  end else begin
                     state_d = ST_ARM;
                     done_d  = 1'b0;
                  end
               end
            end
            ST_ARM: begin
               if (vrise) begin
                  if (skip_cnt_q < skip_q) begin
                     state_d    = ST_SKIP;
                     skip_cnt_d = skip_cnt_q + 8'd1;
                  end else begin
                     state_d = ST_CAPTURE;
                     fs_d    = 1'b1;
                     arm_go  = 1'b1;
                     fwd     = bus.i_pixel_valid & bus.i_vsync;
                  end
               end
            end
            ST_SKIP: begin
               if (vfall) begin
                  state_d = ST_ARM;
               end
            end
            ST_CAPTURE: begin
               fwd = bus.i_pixel_valid & bus.i_vsync;
               if (vfall) begin
                  fe_d = 1'b1;
                  if (idx_q + 8'd1 == cap_q) begin
                     state_d = ST_DONE;
                     done_d  = 1'b1;
                  end else begin
                     state_d = ST_ARM;
                     idx_d   = idx_q + 8'd1;
                  end
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end

      busy_d = (state_d == ST_ARM) || (state_d == ST_SKIP) || (state_d == ST_CAPTURE);
      pv_d   = fwd;
      pd_d   = fwd ? bus.i_pixel_data : pd_q;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q    <= ST_IDLE;
         skip_q     <= '0;
         cap_q      <= '0;
         skip_cnt_q <= '0;
         idx_q      <= '0;
         done_q     <= 1'b0;
         busy_q     <= 1'b0;
         fs_q       <= 1'b0;
         fe_q       <= 1'b0;
         pv_q       <= 1'b0;
         pd_q       <= '0;
         vsync_d1_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         skip_q     <= skip_d;
         cap_q      <= cap_d;
         skip_cnt_q <= skip_cnt_d;
         idx_q      <= idx_d;
         done_q     <= done_d;
         busy_q     <= busy_d;
         fs_q       <= fs_d;
         fe_q       <= fe_d;
         pv_q       <= pv_d;
         pd_q       <= pd_d;
         vsync_d1_q <= bus.i_vsync;
      end
   end

`ifdef FRAME_CAP_GEOM_CHECK_EN
   localparam logic [CNT_W-1:0] BEATS_PER_LINE  = CNT_W'(IMG_WIDTH / PIXEL_PER_CLOCK);
   localparam logic [CNT_W-1:0] LINES_PER_FRAME = CNT_W'(IMG_HEIGHT);

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == '1) ? v : v + 1'b1;
   endfunction

   logic             hsync_d1_q;
   logic [CNT_W-1:0] beat_q, beat_d, beat_now;
   logic [CNT_W-1:0] line_q, line_d, line_now;
   logic             hfall;
   logic             err_d;

   // Counts only cover captured frames; they restart at the vsync rise that
   // opens a capture, where the coincident beat is already the first one.
   always_comb begin
      hfall    = ~bus.i_hsync & hsync_d1_q;
      beat_now = fwd ? sat_inc(beat_q) : beat_q;
      line_now = hfall ? sat_inc(line_q) : line_q;
      beat_d   = beat_q;
      line_d   = line_q;
      err_d    = err_clr ? 1'b0 : err_q;
      if (arm_go) begin
         beat_d = {{(CNT_W-1){1'b0}}, fwd};
         line_d = '0;
      end else if (state_q == ST_CAPTURE) begin
         beat_d = hfall ? '0 : beat_now;
         line_d = line_now;
         if (hfall && (beat_now != BEATS_PER_LINE)) begin
            err_d = 1'b1;
         end
         if (vfall && (line_now != LINES_PER_FRAME)) begin
            err_d = 1'b1;
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         hsync_d1_q <= 1'b0;
         beat_q     <= '0;
         line_q     <= '0;
         err_q      <= 1'b0;
      end else begin
         hsync_d1_q <= bus.i_hsync;
         beat_q     <= beat_d;
         line_q     <= line_d;
         err_q      <= err_d;
      end
   end
`else
   logic [31:0] unused_geom_cfg;
   assign unused_geom_cfg = 32'(IMG_WIDTH + IMG_HEIGHT + PIXEL_PER_CLOCK + CNT_W)
                          ^ {31'd0, bus.i_hsync} ^ {31'd0, arm_go} ^ {31'd0, err_clr};
   assign err_q = 1'b0;
`endif

   assign bus.o_pixel_valid = pv_q;
   assign bus.o_pixel_data  = pd_q;
   assign bus.o_frame_start = fs_q;
   assign bus.o_frame_end   = fe_q;
   assign bus.o_frame_idx   = idx_q;
   assign bus.o_busy        = busy_q;
   assign bus.o_done        = done_q;
   assign bus.o_err_geom    = err_q;

endmodule

// File: tb/tb_frame_capture_ctrl.sv
// Directed bench for frame_capture_ctrl on a 16x4 image; forwarded beats are
// checked against a scoreboard queue filled as beats are driven.
module tb_frame_capture_ctrl;

`ifdef FRAME_CAP_GEOM_CHECK_EN
   localparam logic GEOM_EXP = 1'b1;
`else
   localparam logic GEOM_EXP = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;

   frame_capture_ctrl_if bus ();

   frame_capture_ctrl #(
      .IMG_WIDTH       (16),
      .IMG_HEIGHT      (4),
      .PIXEL_PER_CLOCK (4),
      .CNT_W           (16)
   ) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int          n_vec = 0;
   int          n_err = 0;
   int          fs_cnt = 0;
   int          fe_cnt = 0;
   logic [63:0] exp_q[$];
   logic [7:0]  fs_idx_q[$];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock: drive inputs, push the beat if it must be forwarded, then
   // check the registered outputs 1 time unit after the edge.
   task automatic cyc(input logic vs, input logic hs, input logic pv, input logic fwd);
      logic [63:0] d;
      logic        ev;
      d = {$urandom, $urandom};
      bus.i_vsync       = vs;
      bus.i_hsync       = hs;
      bus.i_pixel_valid = pv;
      bus.i_pixel_data  = d;
      if (fwd) exp_q.push_back(d);
      @(posedge clk);
      #1;
      bus.i_start = 1'b0;
      bus.i_abort = 1'b0;
      ev = (exp_q.size() != 0);
      chk("pix_valid", bus.o_pixel_valid, ev);
      if (ev) chk("pix_data", bus.o_pixel_data, exp_q.pop_front());
      if (bus.o_frame_start) begin
         fs_cnt++;
         fs_idx_q.push_back(bus.o_frame_idx);
      end
      if (bus.o_frame_end) fe_cnt++;
   endtask

   task automatic frame(input int lines, input int beats, input logic cap,
                        input int start_at, input int abort_at);
      int   c;
      logic live;
      c    = 0;
      live = cap;
      for (int l = 0; l < lines; l++) begin
         for (int b = 0; b <= beats; b++) begin
            if (c == start_at) bus.i_start = 1'b1;
            if (c == abort_at) begin
               bus.i_abort = 1'b1;
               live = 1'b0;
            end
            cyc(1'b1, b < beats, b < beats, live && (b < beats));
            c++;
         end
      end
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic start_cmd(input logic [7:0] skip, input logic [7:0] cap);
      bus.i_skip_frames    = skip;
      bus.i_capture_frames = cap;
      bus.i_start          = 1'b1;
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic clr_counts();
      fs_cnt = 0;
      fe_cnt = 0;
      fs_idx_q.delete();
   endtask

   initial begin
      bus.i_start = 1'b0;
      bus.i_abort = 1'b0;
      bus.i_skip_frames = '0;
      bus.i_capture_frames = '0;
      bus.i_hsync = 1'b0;
      bus.i_vsync = 1'b0;
      bus.i_pixel_valid = 1'b0;
      bus.i_pixel_data = '0;

      repeat (2) @(posedge clk);
      #1;
      chk("rst_pv", bus.o_pixel_valid, 0);
      chk("rst_pd", bus.o_pixel_data, 0);
      chk("rst_fs", bus.o_frame_start, 0);
      chk("rst_fe", bus.o_frame_end, 0);
      chk("rst_idx", bus.o_frame_idx, 0);
      chk("rst_busy", bus.o_busy, 0);
      chk("rst_done", bus.o_done, 0);
      chk("rst_err", bus.o_err_geom, 0);
      rst = 1'b0;
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      frame(4, 4, 1'b0, -1, -1);

      // basic: skip 0, capture 2, four frames offered
      clr_counts();
      start_cmd(8'd0, 8'd2);
      chk("t1_busy", bus.o_busy, 1);
      chk("t1_done0", bus.o_done, 0);
      frame(4, 4, 1'b1, -1, -1);
      frame(4, 4, 1'b1, -1, -1);
      chk("t1_done_early", bus.o_done, 1);
      frame(4, 4, 1'b0, -1, -1);
      frame(4, 4, 1'b0, -1, -1);
      chk("t1_fs_cnt", fs_cnt, 2);
      chk("t1_fe_cnt", fe_cnt, 2);
      if (fs_idx_q.size() == 2) begin
         chk("t1_idx0", fs_idx_q[0], 0);
         chk("t1_idx1", fs_idx_q[1], 1);
      end else begin
         chk("t1_fs_idx_size", fs_idx_q.size(), 2);
      end
      chk("t1_idx_last", bus.o_frame_idx, 1);
      chk("t1_done", bus.o_done, 1);
      chk("t1_busy_end", bus.o_busy, 0);
      chk("t1_err", bus.o_err_geom, 0);

      // skip 2, capture 1: third frame only
      clr_counts();
      start_cmd(8'd2, 8'd1);
      chk("t2_done_clr", bus.o_done, 0);
      frame(4, 4, 1'b0, -1, -1);
      frame(4, 4, 1'b0, -1, -1);
      frame(4, 4, 1'b1, -1, -1);
      frame(4, 4, 1'b0, -1, -1);
      chk("t2_fs_cnt", fs_cnt, 1);
      chk("t2_fe_cnt", fe_cnt, 1);
      chk("t2_idx", bus.o_frame_idx, 0);
      chk("t2_done", bus.o_done, 1);

      // start while vsync is high: partial frame dropped
      clr_counts();
      bus.i_skip_frames = 8'd0;
      bus.i_capture_frames = 8'd1;
      frame(4, 4, 1'b0, 7, -1);
      chk("t3_busy", bus.o_busy, 1);
      frame(4, 4, 1'b1, -1, -1);
      chk("t3_fs_cnt", fs_cnt, 1);
      chk("t3_done", bus.o_done, 1);

      // abort on line 1 of the first captured frame
      clr_counts();
      start_cmd(8'd0, 8'd1);
      frame(4, 4, 1'b1, -1, 5);
      chk("t4_fs_cnt", fs_cnt, 1);
      chk("t4_fe_cnt", fe_cnt, 0);
      chk("t4_done", bus.o_done, 0);
      chk("t4_busy", bus.o_busy, 0);
      frame(4, 4, 1'b0, -1, -1);
      chk("t4_fs_idle", fs_cnt, 1);

      // short lines
      clr_counts();
      start_cmd(8'd0, 8'd1);
      frame(4, 3, 1'b1, -1, -1);
      chk("t5_err_beats", bus.o_err_geom, GEOM_EXP);
      chk("t5_done", bus.o_done, 1);

      // capture 0: done next cycle, error cleared, nothing forwarded
      clr_counts();
      start_cmd(8'd0, 8'd0);
      chk("t6_done", bus.o_done, 1);
      chk("t6_err_clr", bus.o_err_geom, 0);
      chk("t6_busy", bus.o_busy, 0);
      frame(4, 4, 1'b0, -1, -1);
      chk("t6_fs_cnt", fs_cnt, 0);

      // short frame
      clr_counts();
      start_cmd(8'd0, 8'd1);
      frame(3, 4, 1'b1, -1, -1);
      chk("t7_err_lines", bus.o_err_geom, GEOM_EXP);
      chk("t7_done", bus.o_done, 1);
      chk("t7_fe_cnt", fe_cnt, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
